// File: rtl/mem_link_controller.sv
`default_nettype none
// ============================================================================
// mem_link_controller : start-bit serial memory link (TX framer, RX framer,
// outstanding-read credits). Optional watchdog: MEM_LINK_TIMEOUT_EN.
// Rev 1.0
// ============================================================================
module mem_link_controller #(
  parameter int IO_BITS           = 2,
  parameter int HEADER_CYCLES     = 1,
  parameter int WR_PAYLOAD_CYCLES = 8,
  parameter int RD_PAYLOAD_CYCLES = 4,
  parameter int RX_PAYLOAD_CYCLES = 8,
  parameter int MAX_OUTSTANDING   = 2,
`ifdef MEM_LINK_TIMEOUT_EN
  parameter int TIMEOUT_CYCLES    = 64,
`endif
  parameter int CNT_W = $clog2(
      (((HEADER_CYCLES > WR_PAYLOAD_CYCLES) ? HEADER_CYCLES : WR_PAYLOAD_CYCLES) >
       ((RD_PAYLOAD_CYCLES > RX_PAYLOAD_CYCLES) ? RD_PAYLOAD_CYCLES : RX_PAYLOAD_CYCLES))
      ? ((HEADER_CYCLES > WR_PAYLOAD_CYCLES) ? HEADER_CYCLES : WR_PAYLOAD_CYCLES)
      : ((RD_PAYLOAD_CYCLES > RX_PAYLOAD_CYCLES) ? RD_PAYLOAD_CYCLES : RX_PAYLOAD_CYCLES)) + 1
) (
  input  logic                                   clk,
  input  logic                                   reset_n,
  input  logic                                   tx_command_valid,
  input  logic [IO_BITS-1:0]                     tx_command,
  output logic                                   tx_command_started,
  output logic                                   tx_blocked,
  output logic                                   tx_active,
  input  logic [IO_BITS-1:0]                     tx_data,
  output logic                                   tx_data_next,
  output logic [CNT_W-1:0]                       tx_counter,
  output logic                                   tx_done,
  output logic                                   rx_started,
  output logic                                   rx_active,
  output logic [IO_BITS-1:0]                     rx_sbs,
  output logic                                   rx_data_valid,
  output logic [CNT_W-1:0]                       rx_counter,
  output logic                                   rx_done,
  output logic                                   rx_unexpected,
  output logic                                   rx_timeout,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   outstanding,
  output logic [IO_BITS-1:0]                     tx_pins,
  input  logic [IO_BITS-1:0]                     rx_pins
);

  localparam int OUT_W = $clog2(MAX_OUTSTANDING+1);
  localparam logic [CNT_W-1:0] HDR_LAST = CNT_W'(HEADER_CYCLES-1);
  localparam logic [CNT_W-1:0] WR_LAST  = CNT_W'(WR_PAYLOAD_CYCLES-1);
  localparam logic [CNT_W-1:0] RD_LAST  = CNT_W'(RD_PAYLOAD_CYCLES-1);
  localparam logic [CNT_W-1:0] RX_LAST  = CNT_W'(RX_PAYLOAD_CYCLES-1);

  typedef enum logic [1:0] {TX_IDLE = 2'd0, TX_HDR = 2'd1, TX_PAY = 2'd2} tx_state_t;
  typedef enum logic {RX_IDLE = 1'b0, RX_DATA = 1'b1} rx_state_t;

  tx_state_t          tx_state, tx_state_nx;
  rx_state_t          rx_state, rx_state_nx;
  logic [CNT_W-1:0]   tx_cnt, tx_cnt_nx, rx_cnt, rx_cnt_nx;
  logic [IO_BITS-1:0] pins;
  logic               tx_rd, cmd_rd, credits_full, tx_start;
  logic               inc, dec, timeout;

  assign cmd_rd       = tx_command[IO_BITS-1];
  assign credits_full = (outstanding == OUT_W'(MAX_OUTSTANDING));
  // Start/observe strobes are gated so every output reads 0 while in reset.
  assign tx_start     = reset_n && (tx_state == TX_IDLE) && tx_command_valid && !(cmd_rd && credits_full);
  assign tx_blocked   = reset_n && (tx_state == TX_IDLE) && tx_command_valid && cmd_rd && credits_full;
  assign tx_command_started = tx_start;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
      tx_rd    <= 1'b0;
    end else begin
      tx_state <= tx_state_nx;
      tx_cnt   <= tx_cnt_nx;
      if (tx_start) tx_rd <= cmd_rd;
    end
  end

  always_comb begin
    tx_state_nx  = tx_state;
    tx_cnt_nx    = tx_cnt;
    pins         = '0;
    tx_data_next = 1'b0;
    tx_done      = 1'b0;
    case (tx_state)
      TX_IDLE: begin
        pins      = IO_BITS'(tx_start);
        tx_cnt_nx = '0;
        if (tx_start) tx_state_nx = TX_HDR;
      end
      TX_HDR: begin
        pins = tx_command;
        if (tx_cnt == HDR_LAST) begin
          tx_cnt_nx   = '0;
          tx_state_nx = TX_PAY;
        end else begin
          tx_cnt_nx = tx_cnt + 1'b1;
        end
      end
      TX_PAY: begin
        pins         = tx_data;
        tx_data_next = 1'b1;
        if (tx_cnt == (tx_rd ? RD_LAST : WR_LAST)) begin
          tx_done     = 1'b1;
          tx_cnt_nx   = '0;
          tx_state_nx = TX_IDLE;
        end else begin
          tx_cnt_nx = tx_cnt + 1'b1;
        end
      end
      default: begin
        tx_state_nx = TX_IDLE;
        tx_cnt_nx   = '0;
      end
    endcase
  end

  assign tx_pins    = reset_n ? pins : '0;
  assign tx_active  = (tx_state != TX_IDLE);
  assign tx_counter = (tx_state == TX_PAY) ? tx_cnt : '0;

  assign rx_started = reset_n && (rx_state == RX_IDLE) && (rx_pins != '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_sbs   <= '0;
    end else begin
      rx_state <= rx_state_nx;
      rx_cnt   <= rx_cnt_nx;
      if (rx_started) rx_sbs <= rx_pins;
    end
  end

  always_comb begin
    rx_state_nx = rx_state;
    rx_cnt_nx   = '0;
    rx_done     = 1'b0;
    case (rx_state)
      RX_IDLE: if (rx_started) rx_state_nx = RX_DATA;
      RX_DATA: begin
        if (rx_cnt == RX_LAST) begin
          rx_done     = 1'b1;
          rx_state_nx = RX_IDLE;
        end else begin
          rx_cnt_nx = rx_cnt + 1'b1;
        end
      end
      default: rx_state_nx = RX_IDLE;
    endcase
  end

  assign rx_active     = (rx_state == RX_DATA);
  assign rx_data_valid = (rx_state == RX_DATA);
  assign rx_counter    = rx_cnt;

  // Credit accounting: a coincident increment and decrement cancel out.
  assign inc           = tx_start && cmd_rd;
  assign dec           = rx_done || timeout;
  assign rx_unexpected = rx_done && (outstanding == '0) && !inc;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      outstanding <= '0;
    end else if (inc && !dec) begin
      outstanding <= outstanding + 1'b1;
    end else if (!inc && dec && (outstanding != '0)) begin
      outstanding <= outstanding - 1'b1;
    end
  end

`ifdef MEM_LINK_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES) + 1;
  logic [WD_W-1:0] wd_cnt;

  assign timeout    = (outstanding != '0) && !rx_started && (wd_cnt == WD_W'(TIMEOUT_CYCLES-1));
  assign rx_timeout = timeout;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wd_cnt <= '0;
    end else if (rx_started || (outstanding == '0) || timeout) begin
      wd_cnt <= '0;
    end else begin
      wd_cnt <= wd_cnt + 1'b1;
    end
  end
`else
  assign timeout    = 1'b0;
  assign rx_timeout = 1'b0;
`endif

endmodule
`default_nettype wire
